// File: rtl/baccarat_pkg.sv
// Shared encodings for the baccarat deal controller: FSM states, card codes, score limits.
// Pure declarations; no logic, no latency.
package baccarat_pkg;

    typedef enum logic [2:0] {
        S_P1,
        S_D1,
        S_P2,
        S_D2,
        S_THIRD,
        S_BANKER,
        S_DONE
    } deal_state_t;

    localparam logic [3:0] CARD_BLANK  = 4'd0;
    localparam logic [3:0] CARD_ACE    = 4'd1;
    localparam logic [3:0] CARD_TEN    = 4'd10;
    localparam logic [3:0] CARD_KING   = 4'd13;

    localparam logic [3:0] NATURAL_MIN = 4'd8;
    localparam logic [3:0] SCORE_MAX   = 4'd9;
    localparam logic [3:0] DRAW_MAX    = 4'd5;

    // Tens and face cards count as zero; blank and out-of-range codes do too.
    function automatic logic [3:0] card_value(input logic [3:0] code);
        if (code >= CARD_ACE && code < CARD_TEN)
            return code;
        else
            return 4'd0;
    endfunction

    // Scores above 9 never come from the datapath; they are treated as non-natural.
    function automatic logic is_natural(input logic [3:0] score);
        return (score >= NATURAL_MIN) && (score <= SCORE_MAX);
    endfunction

endpackage

// File: rtl/baccarat_banker_rule.sv
// Banker third-card tableau: decides whether the dealer draws given its score and the player's third card.
// Purely combinational, zero latency; no flow control.
module baccarat_banker_rule
    import baccarat_pkg::*;
(
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       draw
);

    logic [3:0] v;

    always_comb begin
        v    = card_value(pcard3);
        draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (v != 4'd8);
            4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
            4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
            4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
            default:          draw = 1'b0;
        endcase
    end

endmodule

// File: rtl/baccarat_deal_ctrl.sv
// Baccarat deal sequencer: one card per advance strobe, Mealy load pulses, third-card rules, win lights.
// State moves only on advance; optional cards_dealt counter under DEAL_COUNT_EN.
module baccarat_deal_ctrl
    import baccarat_pkg::*;
(
    input  logic       slow_clock,
    input  logic       reset,
    input  logic       advance,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic       hand_done
`ifdef DEAL_COUNT_EN
    ,
    output logic [2:0] cards_dealt
`endif
);

    deal_state_t state;
    deal_state_t nxt;
    logic        step;
    logic        banker_draw;

    // Reset wins over advance, so a colliding strobe issues no load.
    assign step = advance & ~reset;

    baccarat_banker_rule u_banker_rule (
        .dscore (dscore),
        .pcard3 (pcard3),
        .draw   (banker_draw)
    );

    always_comb begin
        load_pcard1 = 1'b0;
        load_pcard2 = 1'b0;
        load_pcard3 = 1'b0;
        load_dcard1 = 1'b0;
        load_dcard2 = 1'b0;
        load_dcard3 = 1'b0;
        nxt         = state;
        if (step) begin
            case (state)
                S_P1: begin
                    load_pcard1 = 1'b1;
                    nxt         = S_D1;
                end
                S_D1: begin
                    load_dcard1 = 1'b1;
                    nxt         = S_P2;
                end
                S_P2: begin
                    load_pcard2 = 1'b1;
                    nxt         = S_D2;
                end
                S_D2: begin
                    load_dcard2 = 1'b1;
                    nxt         = S_THIRD;
                end
                S_THIRD: begin
                    if (is_natural(pscore) || is_natural(dscore)) begin
                        nxt = S_DONE;
                    end else if (pscore <= DRAW_MAX) begin
                        load_pcard3 = 1'b1;
                        nxt         = S_BANKER;
                    end else if (dscore <= DRAW_MAX) begin
                        load_dcard3 = 1'b1;
                        nxt         = S_DONE;
                    end else begin
                        nxt = S_DONE;
                    end
                end
                S_BANKER: begin
                    load_dcard3 = banker_draw;
                    nxt         = S_DONE;
                end
                S_DONE:  nxt = S_DONE;
                default: nxt = S_P1;
            endcase
        end
    end

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            state     <= S_P1;
            hand_done <= 1'b0;
        end else begin
            state     <= nxt;
            hand_done <= (nxt == S_DONE);
        end
    end

    // Lights follow the live scores once the hand is over; a tie lights both.
    assign player_win_light = hand_done && (pscore >= dscore);
    assign dealer_win_light = hand_done && (dscore >= pscore);

`ifdef DEAL_COUNT_EN
    logic any_load;

    assign any_load = load_pcard1 | load_pcard2 | load_pcard3 |
                      load_dcard1 | load_dcard2 | load_dcard3;

    always_ff @(posedge slow_clock) begin
        if (reset)
            cards_dealt <= 3'd0;
        else if (any_load && (cards_dealt != 3'd6))
            cards_dealt <= cards_dealt + 3'd1;
    end
`endif

endmodule

// File: tb/tb_baccarat_deal_ctrl.sv
// Scoreboarded bench for baccarat_deal_ctrl: stimulus pushes expected load vectors, a negedge monitor pops and compares.
module tb_baccarat_deal_ctrl;

    logic       slow_clock = 1'b0;
    logic       reset      = 1'b1;
    logic       advance    = 1'b0;
    logic [3:0] pscore     = 4'd0;
    logic [3:0] dscore     = 4'd0;
    logic [3:0] pcard3     = 4'd0;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light, hand_done;
`ifdef DEAL_COUNT_EN
    logic [2:0] cards_dealt;
`endif

    baccarat_deal_ctrl dut (
        .slow_clock       (slow_clock),
        .reset            (reset),
        .advance          (advance),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
        .hand_done        (hand_done)
`ifdef DEAL_COUNT_EN
        ,
        .cards_dealt      (cards_dealt)
`endif
    );

    always #5 slow_clock = ~slow_clock;

    // Load vector bit order: 0 pc1, 1 dc1, 2 pc2, 3 dc2, 4 pc3, 5 dc3.
    logic [5:0] exp_q[$];
    int         errors = 0;
    int         checks = 0;
    bit         mon_en = 1'b0;

    // Reference: number of deal steps taken; 0..3 the four opening cards,
    // 4 awaiting third-card decision, 5 awaiting banker decision, 6 hand over.
    int         model_step = 0;
    int         model_cards = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int val_of(input int code);
        return (code >= 1 && code <= 9) ? code : 0;
    endfunction

    function automatic bit natural(input int s);
        return (s == 8) || (s == 9);
    endfunction

    function automatic bit banker_draws(input int d, input int code);
        int v;
        v = val_of(code);
        if (d <= 2) return 1'b1;
        if (d == 3) return v != 8;
        if (d >= 4 && d <= 6) return (v >= 2 * (d - 3)) && (v <= 7);
        return 1'b0;
    endfunction

    // Expected loads and next step for one advance at the given scores.
    task automatic model_adv(input int st, input int p, input int d, input int c,
                             output logic [5:0] ld, output int nst);
        ld  = 6'b0;
        nst = st;
        if (st < 4) begin
            ld[st] = 1'b1;
            nst    = st + 1;
        end else if (st == 4) begin
            nst = 6;
            if (natural(p) || natural(d)) ld = 6'b0;
            else if (p <= 5) begin ld[4] = 1'b1; nst = 5; end
            else if (d <= 5) ld[5] = 1'b1;
        end else if (st == 5) begin
            ld[5] = banker_draws(d, c);
            nst   = 6;
        end
    endtask

    always @(negedge slow_clock) begin
        if (mon_en) begin
            logic [5:0] act;
            logic [5:0] e;
            bit         done_m;
            act = {load_dcard3, load_pcard3, load_dcard2, load_pcard2, load_dcard1, load_pcard1};
            if (advance) begin
                if (exp_q.size() == 0) begin
                    chk("loads_unexpected_strobe", int'(act), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("loads_on_advance", int'(act), int'(e));
                end
            end else begin
                chk("loads_idle", int'(act), 0);
            end
            done_m = (model_step == 6);
            chk("hand_done", int'(hand_done), int'(done_m));
            chk("player_win_light", int'(player_win_light),
                int'(done_m && (int'(pscore) >= int'(dscore))));
            chk("dealer_win_light", int'(dealer_win_light),
                int'(done_m && (int'(dscore) >= int'(pscore))));
`ifdef DEAL_COUNT_EN
            chk("cards_dealt", int'(cards_dealt), model_cards);
`endif
        end
    end

    task automatic adv(input int p, input int d, input int c);
        logic [5:0] ld;
        int         nst;
        pscore = 4'(p);
        dscore = 4'(d);
        pcard3 = 4'(c);
        model_adv(model_step, p, d, c, ld, nst);
        exp_q.push_back(ld);
        advance = 1'b1;
        @(posedge slow_clock);
        model_step = nst;
        if (ld != 6'b0 && model_cards < 6) model_cards++;
        #1 advance = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge slow_clock);
            #1;
        end
    endtask

    task automatic do_reset(input bit with_adv);
        reset   = 1'b1;
        advance = with_adv;
        if (with_adv) exp_q.push_back(6'b0);
        @(posedge slow_clock);
        model_step  = 0;
        model_cards = 0;
        #1;
        reset   = 1'b0;
        advance = 1'b0;
    endtask

    task automatic deal_four();
        for (int i = 0; i < 4; i++)
            adv($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 13));
    endtask

    task automatic set_scores(input int p, input int d);
        pscore = 4'(p);
        dscore = 4'(d);
        tick(1);
    endtask

    initial begin
        tick(2);
        reset  = 1'b0;
        mon_en = 1'b1;
        tick(2);

        // Opening four cards, then natural for the player.
        deal_four();
        adv(8, 3, 0);
        tick(1);
        adv(8, 3, 0);
        adv(8, 3, 0);

        // Player draws, banker draws on 5 vs a 6; dealer wins afterward.
        do_reset(1'b0);
        deal_four();
        adv(4, 5, 0);
        adv(4, 5, 6);
        set_scores(2, 7);

        // Banker on 3 against an 8 stands, against a queen draws.
        do_reset(1'b0);
        deal_four();
        adv(3, 3, 0);
        adv(3, 3, 8);
        do_reset(1'b0);
        deal_four();
        adv(3, 3, 0);
        adv(3, 3, 12);

        // Full banker tableau sweep.
        for (int d = 0; d <= 7; d++) begin
            for (int c = 0; c <= 13; c++) begin
                do_reset(1'b0);
                deal_four();
                adv($urandom_range(0, 5), d, 0);
                adv($urandom_range(0, 9), d, c);
            end
        end

        // Player stands on 7: banker draws on 5, stands on 6; tie lights both.
        do_reset(1'b0);
        deal_four();
        adv(7, 5, 0);
        do_reset(1'b0);
        deal_four();
        adv(7, 6, 0);
        set_scores(7, 7);

        // Reset colliding with advance in the banker state.
        do_reset(1'b0);
        deal_four();
        adv(1, 1, 0);
        do_reset(1'b1);
        tick(2);

        // Random hands with random idles, mid-hand aborts and post-hand strobes.
        for (int h = 0; h < 150; h++) begin
            int extra;
            do_reset($urandom_range(0, 1) == 1);
            extra = $urandom_range(0, 2);
            while (model_step != 6 || extra > 0) begin
                if (model_step == 6) extra--;
                if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 2));
                if ($urandom_range(0, 24) == 0) begin
                    do_reset(1'b1);
                end else begin
                    adv($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 13));
                end
            end
            set_scores($urandom_range(0, 9), $urandom_range(0, 9));
        end

        tick(2);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
